// File: rtl/fizzbuzz_sequencer_if.sv
// Token stream between the sequencer and the downstream formatter.
// The producer drives number/flags/valid and the consumer drives ready.
interface fizzbuzz_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_number;
  logic             out_fizz;
  logic             out_buzz;
  logic             out_last;

  modport master (
    output out_valid,
    output out_number,
    output out_fizz,
    output out_buzz,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_number,
    input  out_fizz,
    input  out_buzz,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fizzbuzz_sequencer.sv
// Walks an inclusive WIDTH-bit range and emits one {number, fizz, buzz, last}
// token per value. A single reciprocal multiplier is time-shared between the
// divide-by-3 test (TEST3) and the divide-by-5 test (TEST5).
module fizzbuzz_sequencer #(
  parameter int WIDTH  = 8,
  parameter int RECIP3 = 171,
  parameter int FRAC3  = 9,
  parameter int RECIP5 = 205,
  parameter int FRAC5  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  fizzbuzz_sequencer_if.master out_if
);

  // The shared multiplier is as wide as the larger fractional field; the
  // narrower divisor masks its product down before comparing.
  localparam int FRAC_MAX = (FRAC3 > FRAC5) ? FRAC3 : FRAC5;
  localparam logic [FRAC_MAX-1:0] RECIP3_V = FRAC_MAX'(RECIP3);
  localparam logic [FRAC_MAX-1:0] RECIP5_V = FRAC_MAX'(RECIP5);
  localparam logic [FRAC_MAX-1:0] MASK3    = FRAC_MAX'((64'd1 << FRAC3) - 64'd1);
  localparam logic [FRAC_MAX-1:0] MASK5    = FRAC_MAX'((64'd1 << FRAC5) - 64'd1);

  typedef enum logic [1:0] {IDLE, TEST3, TEST5, EMIT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] last_reg;
  logic             fizz_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_number_reg;
  logic             out_fizz_reg;
  logic             out_buzz_reg;
  logic             out_last_reg;

  logic                handshake;
  logic                is_last;
  logic                sel5;
  logic [FRAC_MAX-1:0] mult_a;
  logic [FRAC_MAX-1:0] recip_sel;
  logic [FRAC_MAX-1:0] mask_sel;
  logic [FRAC_MAX-1:0] prod;
  logic                divisible;

  assign handshake = out_valid_reg && out_if.out_ready;
  assign is_last   = (n_reg == last_reg);

  // Divisibility unit: (n * RECIP) mod 2**FRAC < RECIP  <=>  RECIP's divisor divides n.
  assign sel5      = (state_reg == TEST5);
  assign mult_a    = FRAC_MAX'(n_reg);
  assign recip_sel = sel5 ? RECIP5_V : RECIP3_V;
  assign mask_sel  = sel5 ? MASK5 : MASK3;
  assign prod      = (mult_a * recip_sel) & mask_sel;
  assign divisible = (prod < recip_sel);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort overrides everything except an IDLE start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = TEST3;
      TEST3:   state_next = TEST5;
      TEST5:   state_next = EMIT;
      EMIT:    if (handshake) state_next = is_last ? IDLE : TEST3;
      default: state_next = IDLE;
    endcase
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  // Range counter, divisibility results and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg          <= '0;
      last_reg       <= '0;
      fizz_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_number_reg <= '0;
      out_fizz_reg   <= 1'b0;
      out_buzz_reg   <= 1'b0;
      out_last_reg   <= 1'b0;
    end else begin
      out_valid_reg <= (state_next == EMIT);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_reg == EMIT) && handshake && is_last && !abort;
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_reg    <= first;
            last_reg <= last;
          end
        end
        TEST3: begin
          fizz_reg <= divisible;
        end
        TEST5: begin
          // Token fields load together here and hold through EMIT.
          out_number_reg <= n_reg;
          out_fizz_reg   <= fizz_reg;
          out_buzz_reg   <= divisible;
          out_last_reg   <= is_last;
        end
        EMIT: begin
          if (handshake && !abort && !is_last) begin
            n_reg <= n_reg + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign out_if.out_valid  = out_valid_reg;
  assign out_if.out_number = out_number_reg;
  assign out_if.out_fizz   = out_fizz_reg;
  assign out_if.out_buzz   = out_buzz_reg;
  assign out_if.out_last   = out_last_reg;

endmodule
